instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle control unit for the 8-bit CPU datapath. It runs the fetch/decode/execute/writeback cycle per instruction and drives the datapath enables for PC, IR, ALU, accumulator and MDR. It also controls the memory req/ack handshake, with a bounded wait. It replaces the free-running phase counter with an opcode-aware state machine that can stall on memory.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req is held without mem_ack before bus fault; 0 disables timeout
WAIT_W, 4, width of wait counter; must hold MEM_TIMEOUT

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  enable; sampled only at instruction boundaries
instr  input  8  IR contents; [7:4] opcode, [3:0] operand (address/immediate)
zero_flag  input  1  accumulator zero flag
mem_ack  input  1  memory completes current request this cycle
mem_req  output  1  memory request, held until ack
mem_we  output  1  write qualifier for mem_req
mem_addr_sel  output  1  0 = PC, 1 = instr[3:0]
ir_load  output  1  load IR from memory data
pc_inc  output  1  PC <= PC+1
pc_load  output  1  PC <= instr[3:0]
mdr_load  output  1  latch memory read data into MDR
alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
acc_load  output  1  accumulator write enable
acc_src  output  2  00 ALU, 01 MDR, 10 immediate
fetch, decode, execute, writeback  output  1 each  one-hot phase indicators; all 0 in IDLE/HALT
halted  output  1  in HALT
illegal  output  1  one-cycle pulse on undefined opcode
bus_error  output  1  sticky memory timeout flag

Behaviour:
- Reset is asynchronous and active-high. On assertion, state is IDLE, wait counter and opcode latch are 0, bus_error is 0, and every output is 0 immediately, including mid-handshake.
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 LDI, 9 JMP, A JZ, F HLT. B–E are illegal.
- All outputs are combinational from the registered state, the latched opcode, mem_ack and zero_flag. No output depends on instr except in DECODE.
- Boundary rule: when an instruction completes, next state is FETCH if run=1, else IDLE.
- IDLE: no strobes. run=1 moves to FETCH on the next edge.
- FETCH: fetch=1, mem_req=1, mem_addr_sel=0, mem_we=0. The state holds until mem_ack=1. In the ack cycle, ir_load=1 and pc_inc=1, and the next state is DECODE. Same-cycle ack gives a 1-cycle FETCH.
- DECODE: decode=1 for exactly 1 cycle. The opcode latch captures instr[7:4]; later states use the latch only.
  - NOP goes to the boundary.
  - Illegal: illegal=1 this cycle, then boundary.
  - HLT goes to HALT.
  - LDA and STA go to MEM.
  - All others go to EXEC.
- EXEC: execute=1 for 1 cycle.
  - ALU ops drive alu_op and go to WB.
  - LDI goes to WB.
  - JMP: pc_load=1, then boundary.
  - JZ: pc_load=zero_flag, then boundary.
- MEM: execute=1, mem_req=1, mem_addr_sel=1, mem_we=(op==STA). The state holds until ack.
  - LDA: mdr_load=1 in the ack cycle, then WB.
  - STA: ack goes to the boundary.
- WB: writeback=1 and acc_load=1 for 1 cycle, then boundary.
  - acc_src is 00 for ALU ops, 01 for LDA, 10 for LDI.
  - alu_op holds its EXEC value for ALU ops; otherwise it is 000.
- HALT: halted=1, all other strobes 0. Only reset exits. mem_ack, run and instr are ignored.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on ack. It increments each FETCH/MEM cycle without ack.
  - If MEM_TIMEOUT>0 and a no-ack cycle occurs with count==MEM_TIMEOUT-1, the next state is HALT and bus_error is set. bus_error is sticky until reset.
  - mem_req is therefore high for exactly MEM_TIMEOUT cycles.
  - Ack in the final allowed cycle wins over timeout.
- mem_ack outside FETCH/MEM is ignored.
- run changes mid-instruction have no effect until the boundary.
- Cycle counts with zero-wait memory:
  - 4 cycles: ALU ops, LDI, LDA.
  - 3 cycles: JMP, JZ, STA.
  - 2 cycles: NOP, illegal.

Test Plan:
1. Reset, run=1, instr=0x35 (ADD), ack same cycle as req → FETCH (ir_load, pc_inc), DECODE, EXEC alu_op=000, WB acc_load=1 acc_src=00, then FETCH. Period 4 cycles.
2. instr=0x1A (LDA), ack 3 cycles late in MEM → mem_req=1 with mem_addr_sel=1 for 4 cycles, mdr_load=1 only in the ack cycle, then WB acc_src=01. Repeat with 0x2A (STA): mem_we=1 and no WB.
3. instr=0xA3 (JZ) with zero_flag=1 → pc_load=1 in EXEC. With zero_flag=0 → pc_load=0. Both return to FETCH after 3 cycles.
4. instr=0xC0 → illegal=1 for one cycle in DECODE, then FETCH. instr=0xF0 → halted=1 and stays through 20 cycles of toggling mem_ack/run; only reset clears it.
5. MEM_TIMEOUT=4, mem_ack held 0 in FETCH → mem_req=1 for exactly 4 cycles, then halted=1 and bus_error=1. Ack in the 4th cycle instead → normal DECODE, bus_error=0.
6. run dropped during an LDA MEM wait → LDA completes through WB, then IDLE with all strobes 0. Reset asserted mid-FETCH → mem_req and fetch go to 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Opcode-aware fetch/decode/execute/writeback controller for the
//            8-bit CPU datapath, with bounded memory req/ack wait.
// Revision : 1.0
// ============================================================================
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       zero_flag,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mdr_load,
  output logic [2:0] alu_op,
  output logic       acc_load,
  output logic [1:0] acc_src,
  output logic       fetch,
  output logic       decode,
  output logic       execute,
  output logic       writeback,
  output logic       halted,
  output logic       illegal,
  output logic       bus_error
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_decode = 3'd2;
  localparam logic [2:0] c_st_exec   = 3'd3;
  localparam logic [2:0] c_st_mem    = 3'd4;
  localparam logic [2:0] c_st_wb     = 3'd5;
  localparam logic [2:0] c_st_halt   = 3'd6;

  localparam logic [3:0] c_op_nop = 4'h0;
  localparam logic [3:0] c_op_lda = 4'h1;
  localparam logic [3:0] c_op_sta = 4'h2;
  localparam logic [3:0] c_op_ldi = 4'h8;
  localparam logic [3:0] c_op_jmp = 4'h9;
  localparam logic [3:0] c_op_jz  = 4'hA;
  localparam logic [3:0] c_op_hlt = 4'hF;

  localparam logic [WAIT_W-1:0] c_wait_last =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [3:0]        r_op;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_bus_error;
  logic              w_mem_phase;
  logic              w_timeout;
  logic              w_boundary_fetch;
  logic [3:0]        w_dec_op;
  logic              w_unused;

  assign w_unused = ^instr[3:0];

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= 4'h3) && (op <= 4'h7);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  // ADD..XOR opcodes 3..7 map onto ALU codes 0..4
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [3:0] d;
    d = op - 4'h3;
    return is_alu(op) ? d[2:0] : 3'b000;
  endfunction

  assign w_dec_op         = instr[7:4];
  assign w_boundary_fetch = run;
  assign w_mem_phase      = (r_state == c_st_fetch) || (r_state == c_st_mem);
  assign w_timeout        = (MEM_TIMEOUT > 0) && w_mem_phase && !mem_ack &&
                            (r_wait == c_wait_last);
  assign w_wait_next      = (w_mem_phase && !mem_ack && !w_timeout) ?
                            r_wait + WAIT_W'(1) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_op        <= 4'h0;
      r_wait      <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (r_state == c_st_decode) r_op <= w_dec_op;
      if (w_timeout) r_bus_error <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:   w_next = run ? c_st_fetch : c_st_idle;
      c_st_fetch: begin
        if (mem_ack)        w_next = c_st_decode;
        else if (w_timeout) w_next = c_st_halt;
      end
      c_st_decode: begin
        if (w_dec_op == c_op_nop || is_illegal(w_dec_op))
          w_next = w_boundary_fetch ? c_st_fetch : c_st_idle;
        else if (w_dec_op == c_op_hlt)
          w_next = c_st_halt;
        else if (w_dec_op == c_op_lda || w_dec_op == c_op_sta)
          w_next = c_st_mem;
        else
          w_next = c_st_exec;
      end
      c_st_exec: begin
        if (is_alu(r_op) || r_op == c_op_ldi) w_next = c_st_wb;
        else w_next = w_boundary_fetch ? c_st_fetch : c_st_idle;
      end
      c_st_mem: begin
        if (mem_ack)
          w_next = (r_op == c_op_lda) ? c_st_wb :
                   (w_boundary_fetch ? c_st_fetch : c_st_idle);
        else if (w_timeout)
          w_next = c_st_halt;
      end
      c_st_wb:   w_next = w_boundary_fetch ? c_st_fetch : c_st_idle;
      c_st_halt: w_next = c_st_halt;
      default:   w_next = c_st_idle;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    mdr_load     = 1'b0;
    alu_op       = 3'b000;
    acc_load     = 1'b0;
    acc_src      = 2'b00;
    fetch        = 1'b0;
    decode       = 1'b0;
    execute      = 1'b0;
    writeback    = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    bus_error    = r_bus_error;
    case (r_state)
      c_st_fetch: begin
        fetch   = 1'b1;
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      c_st_decode: begin
        decode  = 1'b1;
        illegal = is_illegal(w_dec_op);
      end
      c_st_exec: begin
        execute = 1'b1;
        alu_op  = alu_code(r_op);
        pc_load = (r_op == c_op_jmp) || ((r_op == c_op_jz) && zero_flag);
      end
      c_st_mem: begin
        execute      = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (r_op == c_op_sta);
        mdr_load     = mem_ack && (r_op == c_op_lda);
      end
      c_st_wb: begin
        writeback = 1'b1;
        acc_load  = 1'b1;
        alu_op    = alu_code(r_op);
        acc_src   = (r_op == c_op_lda) ? 2'b01 :
                    (r_op == c_op_ldi) ? 2'b10 : 2'b00;
      end
      c_st_halt: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Directed self-checking bench for instr_sequencer.
// Revision : 1.0
// ============================================================================
module tb_instr_sequencer;

  logic       clock = 1'b0;
  logic       reset, run, zero_flag, mem_ack;
  logic [7:0] instr;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load, mdr_load;
  logic [2:0] alu_op;
  logic       acc_load;
  logic [1:0] acc_src;
  logic       fetch, decode, execute, writeback, halted, illegal, bus_error;
  int         total = 0;
  int         bad   = 0;

  instr_sequencer #(.MEM_TIMEOUT(4), .WAIT_W(4)) dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr),
    .zero_flag(zero_flag), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .mdr_load(mdr_load),
    .alu_op(alu_op), .acc_load(acc_load), .acc_src(acc_src),
    .fetch(fetch), .decode(decode), .execute(execute),
    .writeback(writeback), .halted(halted), .illegal(illegal),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  localparam logic [19:0] c_req  = 20'h1 << 19;
  localparam logic [19:0] c_we   = 20'h1 << 18;
  localparam logic [19:0] c_asel = 20'h1 << 17;
  localparam logic [19:0] c_ir   = 20'h1 << 16;
  localparam logic [19:0] c_pci  = 20'h1 << 15;
  localparam logic [19:0] c_pcl  = 20'h1 << 14;
  localparam logic [19:0] c_mdr  = 20'h1 << 13;
  localparam logic [19:0] c_acc  = 20'h1 << 9;
  localparam logic [19:0] c_fet  = 20'h1 << 6;
  localparam logic [19:0] c_dec  = 20'h1 << 5;
  localparam logic [19:0] c_exe  = 20'h1 << 4;
  localparam logic [19:0] c_wb   = 20'h1 << 3;
  localparam logic [19:0] c_hlt  = 20'h1 << 2;
  localparam logic [19:0] c_ill  = 20'h1 << 1;
  localparam logic [19:0] c_berr = 20'h1;
  localparam logic [19:0] c_fetch_ack = c_req | c_ir | c_pci | c_fet;
  localparam logic [19:0] c_mem_rd    = c_exe | c_req | c_asel;

  function automatic logic [19:0] alu(input logic [2:0] v);
    return {7'b0, v, 10'b0};
  endfunction

  function automatic logic [19:0] src(input logic [1:0] v);
    return {11'b0, v, 7'b0};
  endfunction

  function automatic logic [19:0] observed();
    return {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load, mdr_load,
            alu_op, acc_load, acc_src, fetch, decode, execute, writeback,
            halted, illegal, bus_error};
  endfunction

  task automatic check(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // inputs are set at posedge+1; check at posedge+3, then advance one cycle
  task automatic cyc(input string tag, input logic [19:0] exp);
    #2;
    check(tag, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; instr = 8'h00; zero_flag = 1'b0;
    @(posedge clock); #1;
    cyc("reset", 20'h0);

    // ADD, SUB, LDI with zero-wait memory
    reset = 1'b0; run = 1'b1; mem_ack = 1'b1; instr = 8'h35;
    cyc("idle_run", 20'h0);
    cyc("add_fetch", c_fetch_ack);
    cyc("add_decode", c_dec);
    cyc("add_exec", c_exe | alu(3'b000));
    cyc("add_wb", c_wb | c_acc | src(2'b00) | alu(3'b000));
    instr = 8'h45;
    cyc("sub_fetch", c_fetch_ack);
    cyc("sub_decode", c_dec);
    cyc("sub_exec", c_exe | alu(3'b001));
    cyc("sub_wb", c_wb | c_acc | alu(3'b001));
    instr = 8'h77;
    cyc("xor_fetch", c_fetch_ack);
    cyc("xor_decode", c_dec);
    cyc("xor_exec", c_exe | alu(3'b100));
    cyc("xor_wb", c_wb | c_acc | alu(3'b100));
    instr = 8'h87;
    cyc("ldi_fetch", c_fetch_ack);
    cyc("ldi_decode", c_dec);
    cyc("ldi_exec", c_exe);
    cyc("ldi_wb", c_wb | c_acc | src(2'b10));

    // LDA with ack in the last allowed MEM cycle, then STA
    instr = 8'h1A;
    cyc("lda_fetch", c_fetch_ack);
    mem_ack = 1'b0;
    cyc("lda_decode", c_dec);
    cyc("lda_mem0", c_mem_rd);
    cyc("lda_mem1", c_mem_rd);
    cyc("lda_mem2", c_mem_rd);
    mem_ack = 1'b1;
    cyc("lda_mem_ack", c_mem_rd | c_mdr);
    mem_ack = 1'b0;
    cyc("lda_wb", c_wb | c_acc | src(2'b01));
    mem_ack = 1'b1; instr = 8'h2A;
    cyc("sta_fetch", c_fetch_ack);
    mem_ack = 1'b0;
    cyc("sta_decode", c_dec);
    cyc("sta_mem0", c_mem_rd | c_we);
    cyc("sta_mem1", c_mem_rd | c_we);
    cyc("sta_mem2", c_mem_rd | c_we);
    mem_ack = 1'b1;
    cyc("sta_mem_ack", c_mem_rd | c_we);

    // JZ taken / not taken, JMP
    instr = 8'hA3; zero_flag = 1'b1;
    cyc("jz1_fetch", c_fetch_ack);
    cyc("jz1_decode", c_dec);
    cyc("jz1_exec", c_exe | c_pcl);
    zero_flag = 1'b0;
    cyc("jz0_fetch", c_fetch_ack);
    cyc("jz0_decode", c_dec);
    cyc("jz0_exec", c_exe);
    instr = 8'h95;
    cyc("jmp_fetch", c_fetch_ack);
    cyc("jmp_decode", c_dec);
    cyc("jmp_exec", c_exe | c_pcl);

    // illegal, NOP, HLT
    instr = 8'hC0;
    cyc("ill_fetch", c_fetch_ack);
    cyc("ill_decode", c_dec | c_ill);
    instr = 8'h00;
    cyc("nop_fetch", c_fetch_ack);
    cyc("nop_decode", c_dec);
    instr = 8'hF0;
    cyc("hlt_fetch", c_fetch_ack);
    cyc("hlt_decode", c_dec);
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0]; run = i[1]; instr = 8'($urandom);
      cyc("halt_hold", c_hlt);
    end
    reset = 1'b1;
    cyc("halt_reset", 20'h0);

    // fetch timeout after exactly 4 request cycles
    reset = 1'b0; run = 1'b1; mem_ack = 1'b0; instr = 8'h00;
    cyc("to_idle", 20'h0);
    cyc("to_fetch0", c_req | c_fet);
    cyc("to_fetch1", c_req | c_fet);
    cyc("to_fetch2", c_req | c_fet);
    cyc("to_fetch3", c_req | c_fet);
    cyc("to_halt", c_hlt | c_berr);
    mem_ack = 1'b1;
    cyc("to_halt_sticky", c_hlt | c_berr);
    reset = 1'b1;
    cyc("to_reset", 20'h0);

    // ack in the 4th fetch cycle beats the timeout
    reset = 1'b0; mem_ack = 1'b0;
    cyc("late_idle", 20'h0);
    cyc("late_fetch0", c_req | c_fet);
    cyc("late_fetch1", c_req | c_fet);
    cyc("late_fetch2", c_req | c_fet);
    mem_ack = 1'b1;
    cyc("late_fetch3", c_fetch_ack);
    cyc("late_decode", c_dec);

    // run dropped mid-LDA finishes the instruction then idles
    instr = 8'h1A;
    cyc("rd_fetch", c_fetch_ack);
    mem_ack = 1'b0; run = 1'b0;
    cyc("rd_decode", c_dec);
    cyc("rd_mem0", c_mem_rd);
    cyc("rd_mem1", c_mem_rd);
    mem_ack = 1'b1;
    cyc("rd_mem_ack", c_mem_rd | c_mdr);
    cyc("rd_wb", c_wb | c_acc | src(2'b01));
    cyc("rd_idle0", 20'h0);
    cyc("rd_idle1", 20'h0);

    // asynchronous reset in the middle of a fetch wait
    run = 1'b1; mem_ack = 1'b0;
    cyc("ar_idle", 20'h0);
    #2;
    check("ar_fetch", c_req | c_fet);
    #3;
    reset = 1'b1;
    #1;
    check("ar_async", 20'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
